// File: rtl/ritc_bit_ctrl_decoder_pkg.sv
// Shared constants and types for the serial bit_control frame decoder.
// The frame layout here must stay in step with the transmitter in the datapath controller.
package ritc_bit_ctrl_decoder_pkg;

  localparam int CHAN_W    = 3;
  localparam int BIT_W     = 4;
  localparam int DELAY_W   = 5;
  localparam int CMD_W     = 2;
  localparam int PAYLOAD_W = CHAN_W + BIT_W + CMD_W + DELAY_W + 1;  // everything between start and stop
  localparam int FRAME_LEN = PAYLOAD_W + 2;

  localparam logic [CHAN_W-1:0] BCAST_CH  = 3'd7;
  localparam logic [BIT_W-1:0]  BCAST_BIT = 4'd13;

  typedef enum logic [CMD_W-1:0] {
    CMD_LOAD_DELAY = 2'b00,
    CMD_BITSLIP    = 2'b01,
    CMD_RSVD_2     = 2'b10,
    CMD_RSVD_3     = 2'b11
  } cmd_e;

  // Field order matches the MSB-first shift, so the shift register casts directly.
  typedef struct packed {
    logic [CHAN_W-1:0]  chan;
    logic [BIT_W-1:0]   bit_addr;
    cmd_e               cmd;
    logic [DELAY_W-1:0] val;
    logic               par;
  } frame_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_STOP  = 2'd2
  } state_e;

  function automatic logic addr_match(input frame_t f,
                                      input logic [CHAN_W-1:0] channel,
                                      input logic [BIT_W-1:0] bit_sel);
    return ((f.chan == channel) || (f.chan == BCAST_CH)) &&
           ((f.bit_addr == bit_sel) || (f.bit_addr == BCAST_BIT));
  endfunction

endpackage

// File: rtl/ritc_bit_ctrl_decoder_if.sv
// Serial control input and decoded strobe outputs of one bit_control receiver.
interface ritc_bit_ctrl_decoder_if;
  import ritc_bit_ctrl_decoder_pkg::*;

  logic               ctrl;
  logic [DELAY_W-1:0] delay;
  logic               delay_load;
  logic               bitslip;
  logic               frame_err;
  logic               busy;

  modport master (output ctrl, input delay, delay_load, bitslip, frame_err, busy);
  modport slave  (input ctrl, output delay, delay_load, bitslip, frame_err, busy);

endinterface

// File: rtl/ritc_bit_ctrl_decoder.sv
// Receives addressed serial control frames and turns them into an IDELAY value/load
// strobe or an ISERDES bitslip strobe, all in the user clock domain.
module ritc_bit_ctrl_decoder
  import ritc_bit_ctrl_decoder_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [CHAN_W-1:0] channel_i,
  input  logic [BIT_W-1:0]  bit_i,
  ritc_bit_ctrl_decoder_if.slave bus
);

  localparam logic [3:0] LAST_CNT = 4'(PAYLOAD_W - 1);

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q;
  logic [PAYLOAD_W-1:0]   shreg_q;
  frame_t                 frame;

  logic [DELAY_W-1:0]     delay_q;
  logic                   load_q, slip_q, err_q;
  logic                   load_d, slip_d, err_d;

  assign frame = shreg_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_SHIFT) begin
        shreg_q <= {shreg_q[PAYLOAD_W-2:0], bus.ctrl};
        cnt_q   <= cnt_q + 4'd1;
      end else begin
        cnt_q   <= '0;
      end
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    load_d  = 1'b0;
    slip_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (bus.ctrl) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == LAST_CNT) state_d = ST_STOP;
      ST_STOP: begin
        // A high stop bit is an error, never a new start: resync through IDLE.
        state_d = ST_IDLE;
        if (bus.ctrl || (^frame)) begin
          err_d = 1'b1;
        end else if (addr_match(frame, channel_i, bit_i)) begin
          case (frame.cmd)
            CMD_LOAD_DELAY: load_d = 1'b1;
            CMD_BITSLIP:    slip_d = 1'b1;
            default:        ;
          endcase
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      delay_q <= '0;
      load_q  <= 1'b0;
      slip_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      load_q  <= load_d;
      slip_q  <= slip_d;
      err_q   <= err_d;
      if (load_d) delay_q <= frame.val;
    end
  end

  assign bus.delay      = delay_q;
  assign bus.delay_load = load_q;
  assign bus.bitslip    = slip_q;
  assign bus.frame_err  = err_q;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ritc_bit_ctrl_decoder.sv
// Directed bench for the bit_control frame decoder: one task per scenario.
module tb_ritc_bit_ctrl_decoder;
  import ritc_bit_ctrl_decoder_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CHAN_W-1:0] channel = '0;
  logic [BIT_W-1:0]  bit_sel = '0;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int load_cnt = 0, slip_cnt = 0, err_cnt = 0, busy_cnt = 0, overlap_cnt = 0;
  int last_load_cyc = -1, prev_load_cyc = -1, last_slip_cyc = -1, last_err_cyc = -1;
  int stop_cyc = 0;

  ritc_bit_ctrl_decoder_if bus ();

  ritc_bit_ctrl_decoder dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .channel_i (channel),
    .bit_i     (bit_sel),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.delay_load) begin
      load_cnt++;
      prev_load_cyc = last_load_cyc;
      last_load_cyc = cyc;
    end
    if (bus.bitslip) begin
      slip_cnt++;
      last_slip_cyc = cyc;
    end
    if (bus.frame_err) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (bus.busy) busy_cnt++;
    if ((32'(bus.delay_load) + 32'(bus.bitslip) + 32'(bus.frame_err)) > 1) overlap_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [FRAME_LEN-1:0] mk_frame(input logic [2:0] chan, input logic [3:0] b,
                                                    input logic [1:0] cmd, input logic [4:0] val,
                                                    input logic flip_par, input logic stop);
    logic [13:0] payload;
    payload = {chan, b, cmd, val};
    return {1'b1, payload, (^payload) ^ flip_par, stop};
  endfunction

  task automatic drive_bits(input logic [FRAME_LEN-1:0] f, input int n);
    for (int i = FRAME_LEN - 1; i >= FRAME_LEN - n; i--) begin
      @(posedge clk);
      #1 bus.ctrl = f[i];
    end
    stop_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1 bus.ctrl = 1'b0;
    end
  endtask

  task automatic chk(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic test_reset;
    bus.ctrl = 1'b0;
    rst_n = 1'b0;
    #12;
    total++; if (bus.delay !== 5'd0)   begin bad++; $display("FAIL rst_delay: got %0h expected 0", bus.delay); end
    total++; if (bus.delay_load !== 1'b0) begin bad++; $display("FAIL rst_load: got %b expected 0", bus.delay_load); end
    total++; if (bus.bitslip !== 1'b0)  begin bad++; $display("FAIL rst_slip: got %b expected 0", bus.bitslip); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b expected 0", bus.frame_err); end
    total++; if (bus.busy !== 1'b0)     begin bad++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_no_match;
    int l0, s0, e0, b0;
    channel = 3'd4; bit_sel = 4'd5;
    l0 = load_cnt; s0 = slip_cnt; e0 = err_cnt; b0 = busy_cnt;
    drive_bits(mk_frame(3'd2, 4'd5, 2'b00, 5'h13, 1'b0, 1'b0), FRAME_LEN);
    idle(4);
    chk("nomatch_load", load_cnt - l0, 0);
    chk("nomatch_slip", slip_cnt - s0, 0);
    chk("nomatch_err", err_cnt - e0, 0);
    chk("nomatch_delay", int'(bus.delay), 0);
    // busy is state!=IDLE: 15 shift cycles plus the stop cycle after the start is seen.
    chk("nomatch_busy_cycles", busy_cnt - b0, 16);
    chk("nomatch_busy_low", int'(bus.busy), 0);
  endtask

  task automatic test_load_match;
    int l0, e0;
    channel = 3'd2; bit_sel = 4'd5;
    l0 = load_cnt; e0 = err_cnt;
    drive_bits(mk_frame(3'd2, 4'd5, 2'b00, 5'h13, 1'b0, 1'b0), FRAME_LEN);
    idle(4);
    chk("load_count", load_cnt - l0, 1);
    chk("load_latency", last_load_cyc, stop_cyc + 1);
    chk("load_delay", int'(bus.delay), 'h13);
    chk("load_err", err_cnt - e0, 0);
  endtask

  task automatic test_bitslip_bcast;
    int l0, s0;
    channel = 3'd6; bit_sel = 4'd15;
    l0 = load_cnt; s0 = slip_cnt;
    drive_bits(mk_frame(3'd7, 4'd13, 2'b01, 5'h0A, 1'b0, 1'b0), FRAME_LEN);
    idle(4);
    chk("slip_count", slip_cnt - s0, 1);
    chk("slip_latency", last_slip_cyc, stop_cyc + 1);
    chk("slip_no_load", load_cnt - l0, 0);
    chk("slip_delay_hold", int'(bus.delay), 'h13);
  endtask

  task automatic test_reserved_cmd;
    int l0, s0, e0;
    channel = 3'd2; bit_sel = 4'd5;
    l0 = load_cnt; s0 = slip_cnt; e0 = err_cnt;
    drive_bits(mk_frame(3'd2, 4'd5, 2'b10, 5'h1C, 1'b0, 1'b0), FRAME_LEN);
    idle(4);
    chk("rsvd_outputs", (load_cnt - l0) + (slip_cnt - s0) + (err_cnt - e0), 0);
    chk("rsvd_delay_hold", int'(bus.delay), 'h13);
  endtask

  task automatic test_parity_err;
    int l0, e0;
    channel = 3'd2; bit_sel = 4'd5;
    l0 = load_cnt; e0 = err_cnt;
    drive_bits(mk_frame(3'd2, 4'd5, 2'b00, 5'h1F, 1'b1, 1'b0), FRAME_LEN);
    idle(4);
    chk("par_err_count", err_cnt - e0, 1);
    chk("par_err_latency", last_err_cyc, stop_cyc + 1);
    chk("par_no_load", load_cnt - l0, 0);
    chk("par_delay_hold", int'(bus.delay), 'h13);
  endtask

  task automatic test_stop_err;
    int l0, e0;
    channel = 3'd2; bit_sel = 4'd5;
    l0 = load_cnt; e0 = err_cnt;
    drive_bits(mk_frame(3'd2, 4'd5, 2'b00, 5'h07, 1'b0, 1'b1), FRAME_LEN);
    idle(1);
    chk("stop_err_no_load", load_cnt - l0, 0);
    drive_bits(mk_frame(3'd2, 4'd5, 2'b00, 5'h07, 1'b0, 1'b0), FRAME_LEN);
    idle(4);
    chk("stop_err_count", err_cnt - e0, 1);
    chk("stop_next_load", load_cnt - l0, 1);
    chk("stop_next_delay", int'(bus.delay), 'h07);
  endtask

  task automatic test_back_to_back;
    int l0, first_stop;
    channel = 3'd2; bit_sel = 4'd5;
    l0 = load_cnt;
    drive_bits(mk_frame(3'd2, 4'd5, 2'b00, 5'h05, 1'b0, 1'b0), FRAME_LEN);
    first_stop = stop_cyc;
    drive_bits(mk_frame(3'd2, 4'd5, 2'b00, 5'h0A, 1'b0, 1'b0), FRAME_LEN);
    idle(4);
    chk("b2b_count", load_cnt - l0, 2);
    chk("b2b_first_at", prev_load_cyc, first_stop + 1);
    chk("b2b_spacing", last_load_cyc - prev_load_cyc, FRAME_LEN);
    chk("b2b_delay", int'(bus.delay), 'h0A);
  endtask

  task automatic test_reset_mid_frame;
    int l0, s0, e0;
    channel = 3'd2; bit_sel = 4'd5;
    l0 = load_cnt; s0 = slip_cnt; e0 = err_cnt;
    drive_bits(mk_frame(3'd2, 4'd5, 2'b00, 5'h1E, 1'b0, 1'b0), 9);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_delay", int'(bus.delay), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.ctrl = 1'b0;
    idle(3);
    chk("midrst_no_pulse", (load_cnt - l0) + (slip_cnt - s0) + (err_cnt - e0), 0);
    drive_bits(mk_frame(3'd2, 4'd5, 2'b00, 5'h11, 1'b0, 1'b0), FRAME_LEN);
    idle(4);
    chk("midrst_next_load", load_cnt - l0, 1);
    chk("midrst_next_delay", int'(bus.delay), 'h11);
  endtask

  initial begin
    bus.ctrl = 1'b0;
    test_reset();
    test_no_match();
    test_load_match();
    test_bitslip_bcast();
    test_reserved_cmd();
    test_parity_err();
    test_stop_err();
    test_back_to_back();
    test_reset_mid_frame();
    chk("strobe_overlap", overlap_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
